// File: rtl/scnn_decompress_ips.sv
// Sequential decoder for SCNN sparse activations: rebuilds a dense vector from
// (value, index) pairs and releases it through a valid/ready handshake.
module scnn_decompress_ips #(
    parameter int unsigned PARAM_IP_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [7:0]                      num_nz,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [15:0]                     in_data,
    input  logic [7:0]                      in_index,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PARAM_IP_SIZE-1:0][15:0]  outputs,
    output logic                            err
);

    localparam logic [7:0]  IpSize = 8'(PARAM_IP_SIZE);
    localparam int unsigned IdxW   = (PARAM_IP_SIZE > 1) ? $clog2(PARAM_IP_SIZE) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StOut
    } state_e;

    state_e                           state_q, state_d;
    logic [PARAM_IP_SIZE-1:0][15:0]   buffer_q, buffer_d;
    logic [7:0]                       count_q, count_d;
    logic [7:0]                       nz_target_q, nz_target_d;
    logic                             err_q, err_d;
    logic [7:0]                       count_inc;

    always_comb begin
        state_d     = state_q;
        buffer_d    = buffer_q;
        count_d     = count_q;
        nz_target_d = nz_target_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        count_inc   = count_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buffer_d = '0;
                    count_d  = 8'd0;
                    err_d    = 1'b0;
                    // Oversized frames are clamped so the count can never pass the buffer size
                    if (num_nz > IpSize) begin
                        nz_target_d = IpSize;
                        err_d       = 1'b1;
                    end else begin
                        nz_target_d = num_nz;
                    end
                    state_d = (nz_target_d == 8'd0) ? StOut : StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = count_inc;
                    if (in_index < IpSize) begin
                        buffer_d[in_index[IdxW-1:0]] = in_data;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (count_inc == nz_target_q) begin
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            buffer_q    <= '0;
            count_q     <= 8'd0;
            nz_target_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buffer_q    <= buffer_d;
            count_q     <= count_d;
            nz_target_q <= nz_target_d;
            err_q       <= err_d;
        end
    end

    assign outputs = buffer_q;
    assign err     = err_q;

endmodule

// File: tb/tb_scnn_decompress_ips.sv
// Self-checking bench for scnn_decompress_ips: directed and randomized frames
// compared against a dense-array reference model.
module tb_scnn_decompress_ips;

    localparam int N = 16;

    logic               clk = 1'b0;
    logic               rst, start, in_valid, in_ready, out_valid, out_ready, err;
    logic [7:0]         num_nz, in_index;
    logic [15:0]        in_data;
    logic [N-1:0][15:0] outputs;

    int checks = 0;
    int errors = 0;

    logic [15:0] pd[$];
    logic [7:0]  pi[$];
    logic [15:0] exp_buf[N];
    bit          exp_err;
    int          exp_acc;
    int          cyc_out, acc_cnt, last_acc;
    bit          timeout, ir_seen;

    scnn_decompress_ips #(.PARAM_IP_SIZE(N)) dut (
        .clk(clk), .rst(rst), .start(start), .num_nz(num_nz),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready), .outputs(outputs), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected dense frame: zeros, then the first min(n, N) pairs applied in order.
    task automatic build_model(input int n);
        exp_acc = (n > N) ? N : n;
        exp_err = (n > N);
        for (int i = 0; i < N; i++) exp_buf[i] = 16'h0;
        for (int k = 0; k < exp_acc; k++) begin
            if (pi[k] < N) exp_buf[pi[k]] = pd[k];
            else exp_err = 1'b1;
        end
    endtask

    function automatic int first_bad();
        int bad = -1;
        for (int i = N - 1; i >= 0; i--) if (outputs[i] !== exp_buf[i]) bad = i;
        return bad;
    endfunction

    task automatic gen_pairs(input int n, input int max_idx);
        pd.delete();
        pi.delete();
        for (int k = 0; k < n; k++) begin
            pd.push_back(16'($urandom));
            pi.push_back(8'($urandom_range(max_idx, 0)));
        end
    endtask

    // gap_mode: 0 = stream, 1 = random gaps, 2 = alternate 1,0,1,0...
    // poke: pulse start (num_nz=1) during LOAD on the second cycle after start.
    task automatic send_frame(input int n, input int gap_mode, input bit poke);
        int k = 0;
        int cyc;
        bit ph = 1'b0;
        start = 1'b1;
        num_nz = 8'(n);
        step();
        start = 1'b0;
        cyc = 1;
        acc_cnt = 0;
        last_acc = -1;
        timeout = 1'b0;
        ir_seen = 1'b0;
        while (!out_valid) begin
            if (cyc > 300) begin
                timeout = 1'b1;
                break;
            end
            in_valid = (k < pd.size()) && (gap_mode == 0 ||
                       (gap_mode == 1 && $urandom_range(1, 0) == 1) ||
                       (gap_mode == 2 && !ph));
            ph = ~ph;
            start = 1'b0;
            if (poke && cyc == 2) begin
                in_valid = 1'b0;
                start = 1'b1;
                num_nz = 8'd1;
            end
            if (in_valid) begin
                in_data = pd[k];
                in_index = pi[k];
            end
            if (in_ready) ir_seen = 1'b1;
            if (in_valid && in_ready) begin
                k++;
                acc_cnt++;
                last_acc = cyc;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        cyc_out = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b err=%b exp 0 0 0", in_ready, out_valid, err);
        end
        checks++;
        if (outputs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", outputs);
        end
        // rst wins over a simultaneous start
        start = 1'b1;
        num_nz = 8'd3;
        step();
        rst = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_same_cycle in_ready got %b exp 0", in_ready);
        end
    endtask

    task automatic test_basic();
        int bad;
        pd = '{16'd7, 16'hFFFB, 16'd1};
        pi = '{8'd2, 8'd9, 8'd15};
        build_model(3);
        send_frame(3, 0, 1'b0);
        checks++;
        if (timeout || cyc_out !== 4) begin
            errors++;
            $display("FAIL basic_latency got %0d (timeout=%b) exp 4", cyc_out, timeout);
        end
        bad = first_bad();
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL basic_outputs idx %0d got %h exp %h", bad, outputs[bad], exp_buf[bad]);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got %b exp 0", err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain out_valid got %b exp 0", out_valid);
        end
    endtask

    task automatic test_empty();
        int bad;
        gen_pairs(0, 15);
        build_model(0);
        send_frame(0, 0, 1'b0);
        checks++;
        if (cyc_out !== 1 || ir_seen || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_latency got %0d ir_seen=%b exp 1 0", cyc_out, ir_seen);
        end
        bad = first_bad();
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL empty_outputs idx %0d got %h exp %h", bad, outputs[bad], exp_buf[bad]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        gen_pairs(3, 15);
        build_model(3);
        send_frame(3, 2, 1'b0);
        checks++;
        if (timeout || acc_cnt !== 3 || cyc_out !== last_acc + 1) begin
            errors++;
            $display("FAIL bp_accept got acc=%0d out=%0d last=%0d exp 3 and last+1",
                     acc_cnt, cyc_out, last_acc);
        end
        for (int c = 0; c < 5; c++) begin
            bad = first_bad();
            checks++;
            if (!out_valid || bad >= 0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%b bad_idx=%0d exp 1 -1", c, out_valid, bad);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release out_valid got %b exp 0", out_valid);
        end
    endtask

    task automatic test_errors();
        int bad;
        gen_pairs(20, 15);
        build_model(20);
        send_frame(20, 0, 1'b0);
        checks++;
        if (timeout || acc_cnt !== 16 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_overflow got acc=%0d err=%b exp 16 1", acc_cnt, err);
        end
        bad = first_bad();
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL err_overflow_out idx %0d got %h exp %h", bad, outputs[bad], exp_buf[bad]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        pd = '{16'h1234, 16'h5678};
        pi = '{8'd200, 8'd5};
        build_model(2);
        send_frame(2, 0, 1'b0);
        bad = first_bad();
        checks++;
        if (err !== exp_err || bad >= 0) begin
            errors++;
            $display("FAIL err_drop got err=%b bad_idx=%0d exp %b -1", err, bad, exp_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        pd = '{16'd4, 16'd8};
        pi = '{8'd3, 8'd3};
        build_model(2);
        send_frame(2, 0, 1'b0);
        checks++;
        if (outputs[3] !== 16'd8 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_dup got out3=%h err=%b exp 0008 0", outputs[3], err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        gen_pairs(5, 15);
        start = 1'b1;
        num_nz = 8'd5;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data = pd[k] | 16'h1;
            in_index = pi[k];
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (outputs !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got out=%h rdy=%b vld=%b exp 0", outputs, in_ready, out_valid);
        end
        pd = '{16'd9};
        pi = '{8'd0};
        build_model(1);
        send_frame(1, 0, 1'b0);
        bad = first_bad();
        checks++;
        if (timeout || bad >= 0) begin
            errors++;
            $display("FAIL rst_mid_frame idx %0d got %h exp %h", bad, outputs[bad], exp_buf[bad]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int bad;
        gen_pairs(3, 15);
        build_model(3);
        send_frame(3, 0, 1'b1);
        bad = first_bad();
        checks++;
        if (timeout || acc_cnt !== 3 || bad >= 0) begin
            errors++;
            $display("FAIL ign_load got acc=%0d bad_idx=%0d exp 3 -1", acc_cnt, bad);
        end
        start = 1'b1;
        num_nz = 8'd1;
        step();
        start = 1'b0;
        bad = first_bad();
        checks++;
        if (out_valid !== 1'b1 || bad >= 0) begin
            errors++;
            $display("FAIL ign_out got vld=%b bad_idx=%0d exp 1 -1", out_valid, bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        gen_pairs(1, 15);
        build_model(1);
        send_frame(1, 0, 1'b0);
        bad = first_bad();
        checks++;
        if (cyc_out !== 2 || bad >= 0) begin
            errors++;
            $display("FAIL b2b got latency=%0d bad_idx=%0d exp 2 -1", cyc_out, bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        int n;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(18, 0);
            gen_pairs(n, 17);
            build_model(n);
            send_frame(n, 1, 1'b0);
            checks++;
            if (timeout || acc_cnt !== exp_acc ||
                cyc_out !== ((exp_acc == 0) ? 1 : last_acc + 1)) begin
                errors++;
                $display("FAIL rand_accept frame %0d got acc=%0d out=%0d exp acc=%0d", f,
                         acc_cnt, cyc_out, exp_acc);
            end
            bad = first_bad();
            checks++;
            if (bad >= 0 || err !== exp_err) begin
                errors++;
                $display("FAIL rand_frame %0d bad_idx=%0d err=%b exp -1 %b", f, bad, err, exp_err);
            end
            repeat ($urandom_range(3, 0)) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_nz = 8'd0;
        in_valid = 1'b0;
        in_data = 16'h0;
        in_index = 8'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
